j_snd_fifo: RTL

Stereo sample buffer downstream of the I2S block: pairs the separately strobed left/right 16-bit samples (`snd_l`/`snd_r` with `snd_l_en`/`snd_r_en`) into stereo frames, buffers them in a small FIFO, and delivers one frame per request from the host audio output side. It absorbs jitter between the Jaguar I2S word clock and the host's fixed output rate. On a shortfall it repeats the last sample and re-primes the buffer.

---
 rtl/j_snd_fifo.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/j_snd_fifo.sv
// j_snd_fifo: pairs L/R I2S strobes into stereo frames, buffers them, serves one frame per out_req.
// Optional saturating ovf/unf counters are built when J_SND_FIFO_STATS_EN is defined.
module j_snd_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int PRIME      = 4
) (
    input  logic                  clk,
    input  logic                  resetl,
    input  logic [15:0]           snd_l,
    input  logic [15:0]           snd_r,
    input  logic                  snd_l_en,
    input  logic                  snd_r_en,
    input  logic                  flush,
    input  logic                  out_req,
    output logic [15:0]           out_l,
    output logic [15:0]           out_r,
    output logic                  out_vld,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  running,
    output logic                  ovf,
    output logic                  unf,
    output logic                  pair_err,
    output logic [7:0]            ovf_cnt,
    output logic [7:0]            unf_cnt
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_L  = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] PRIME_L = (DEPTH_LOG2 + 1)'(PRIME);
    typedef enum logic {PRIMING, RUNNING} state_t;
    state_t state, state_nxt;
    logic [15:0] l_hold, r_hold;
    logic hl, hr, pend;
    logic [31:0] pend_data;
    logic [31:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic empty, full, pop, wr, underrun;
    assign empty    = level == '0;
    assign full     = level == FULL_L;
    assign running  = state == RUNNING;
    assign pop      = out_req && running && !empty && !flush;
    assign underrun = out_req && running && empty && !flush;
    assign wr       = pend && (!full || pop) && !flush;
    // a completed frame waits one cycle in pend; it is dropped here if the buffer stays full
    assign ovf      = pend && full && !pop && !flush;

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            l_hold    <= '0;
            r_hold    <= '0;
            hl        <= 1'b0;
            hr        <= 1'b0;
            pend      <= 1'b0;
            pend_data <= '0;
            pair_err  <= 1'b0;
        end else if (flush) begin
            hl       <= 1'b0;
            hr       <= 1'b0;
            pend     <= 1'b0;
            pair_err <= 1'b0;
        end else begin
            pend     <= 1'b0;
            pair_err <= 1'b0;
            if (snd_l_en && snd_r_en) begin
                pend      <= 1'b1;
                pend_data <= {snd_l, snd_r};
                hl        <= 1'b0;
                hr        <= 1'b0;
                pair_err  <= hl | hr;
            end else if (snd_l_en) begin
                if (hr) begin
                    pend      <= 1'b1;
                    pend_data <= {snd_l, r_hold};
                    hr        <= 1'b0;
                end else begin
                    l_hold   <= snd_l;
                    hl       <= 1'b1;
                    pair_err <= hl;
                end
            end else if (snd_r_en) begin
                if (hl) begin
                    pend      <= 1'b1;
                    pend_data <= {l_hold, snd_r};
                    hl        <= 1'b0;
                end else begin
                    r_hold   <= snd_r;
                    hr       <= 1'b1;
                    pair_err <= hr;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop)
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            level <= level + (DEPTH_LOG2 + 1)'(wr) - (DEPTH_LOG2 + 1)'(pop);
        end
    end

    always_ff @(posedge clk)
        if (wr)
            mem[wr_ptr] <= pend_data;

    // outputs hold their value unless a real pop happens, which gives the repeat-on-shortfall behaviour
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            out_l   <= '0;
            out_r   <= '0;
            out_vld <= 1'b0;
            unf     <= 1'b0;
        end else begin
            out_vld <= out_req;
            unf     <= underrun;
            if (pop)
                {out_l, out_r} <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl)
            state <= PRIMING;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        state_nxt = (flush || underrun) ? PRIMING :
                    (state == PRIMING && level >= PRIME_L) ? RUNNING : state;
    end

`ifdef J_SND_FIFO_STATS_EN
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            ovf_cnt <= '0;
            unf_cnt <= '0;
        end else begin
            if (ovf && ovf_cnt != 8'hFF)
                ovf_cnt <= ovf_cnt + 8'd1;
            if (underrun && unf_cnt != 8'hFF)
                unf_cnt <= unf_cnt + 8'd1;
        end
    end
`else
    assign ovf_cnt = '0;
    assign unf_cnt = '0;
`endif
endmodule
